// File: rtl/signature_test_controller.sv
// Built-in signature test sequencer: clears the CUT, sweeps an exhaustive stimulus count,
// compacts the CUT responses into a 16-bit signature and compares it with a golden value.
module signature_test_controller #(
  parameter int STIM_W     = 8,
  parameter int CUT_LAT    = 1,
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [7:0]  seed,
  input  logic [15:0] golden_sig,
  input  logic [7:0]  cct_output,
  output logic [7:0]  stimulus,
  output logic        cut_clear,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int SAMPLES = 1 << STIM_W;
  localparam int RUN_LEN = CUT_LAT + SAMPLES;

  localparam logic [7:0] STIM_MAX   = 8'(SAMPLES - 1);
  localparam logic [9:0] RUN_LAST   = 10'(RUN_LEN - 1);
  localparam logic [9:0] LAT_CNT    = 10'(CUT_LAT);
  localparam logic [3:0] PRIME_LAST = 4'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    CHECK
  } state_t;

  state_t      state;
  logic [7:0]  seed_q;
  logic [15:0] golden_q;
  logic [3:0]  prime_cnt;
  logic [9:0]  run_cnt;
  logic [7:0]  comp_sum;

  always_comb begin
    comp_sum = signature[7:0] + (seed_q ^ cct_output);
  end

  // run_cnt counts RUN cycles; the first CUT_LAT of them only fill the CUT pipeline.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      stimulus  <= 8'h00;
      signature <= 16'h0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      cut_clear <= 1'b1;
      seed_q    <= 8'h00;
      golden_q  <= 16'h0000;
      prime_cnt <= 4'd0;
      run_cnt   <= 10'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cut_clear <= 1'b0;
          if (start) begin
            seed_q    <= seed;
            golden_q  <= golden_sig;
            signature <= 16'h0000;
            stimulus  <= 8'h00;
            pass      <= 1'b0;
            busy      <= 1'b1;
            cut_clear <= 1'b1;
            prime_cnt <= 4'd0;
            state     <= PRIME;
          end
        end
        PRIME: begin
          if (prime_cnt == PRIME_LAST) begin
            cut_clear <= 1'b0;
            run_cnt   <= 10'd0;
            state     <= RUN;
          end else begin
            prime_cnt <= prime_cnt + 4'd1;
          end
        end
        RUN: begin
          if (stimulus != STIM_MAX) begin
            stimulus <= stimulus + 8'd1;
          end
          if (run_cnt >= LAT_CNT) begin
            signature <= {signature[14:8], comp_sum, signature[15]};
          end
          if (run_cnt == RUN_LAST) begin
            state <= CHECK;
          end else begin
            run_cnt <= run_cnt + 10'd1;
          end
        end
        CHECK: begin
          pass  <= (signature == golden_q);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signature_test_controller.sv
// Scoreboard bench: three controller configurations, each driving a small CUT model;
// expected signatures are queued at start and checked whenever done pulses.
module tb_signature_test_controller;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic        clear0, start0, cut_clear0, busy0, done0, pass0, cut_mode0;
  logic [7:0]  seed0, cct0, stim0;
  logic [15:0] golden0, sig0;
  logic        clear1, start1, cut_clear1, busy1, done1, pass1;
  logic [7:0]  seed1, cct1, stim1;
  logic [15:0] golden1, sig1;
  logic        clear2, start2, cut_clear2, busy2, done2, pass2;
  logic [7:0]  seed2, cct2, stim2, p2a;
  logic [15:0] golden2, sig2;

  signature_test_controller dut0 (
    .clk(clk), .clear(clear0), .start(start0), .seed(seed0), .golden_sig(golden0),
    .cct_output(cct0), .stimulus(stim0), .cut_clear(cut_clear0), .busy(busy0),
    .done(done0), .pass(pass0), .signature(sig0)
  );

  signature_test_controller #(.STIM_W(1), .CUT_LAT(0), .CLR_CYCLES(1)) dut1 (
    .clk(clk), .clear(clear1), .start(start1), .seed(seed1), .golden_sig(golden1),
    .cct_output(cct1), .stimulus(stim1), .cut_clear(cut_clear1), .busy(busy1),
    .done(done1), .pass(pass1), .signature(sig1)
  );

  signature_test_controller #(.STIM_W(3), .CUT_LAT(2), .CLR_CYCLES(3)) dut2 (
    .clk(clk), .clear(clear2), .start(start2), .seed(seed2), .golden_sig(golden2),
    .cct_output(cct2), .stimulus(stim2), .cut_clear(cut_clear2), .busy(busy2),
    .done(done2), .pass(pass2), .signature(sig2)
  );

  // CUT models: dut0 sees a one-stage pipeline, dut2 a two-stage one, both cleared by cut_clear.
  always @(posedge clk) begin
    if (cut_clear0) cct0 <= 8'h00;
    else            cct0 <= cut_mode0 ? ((stim0 ^ 8'hA5) + 8'd17) : 8'h00;
    if (cut_clear2) begin
      p2a  <= 8'h00;
      cct2 <= 8'h00;
    end else begin
      p2a  <= stim2 * 8'd37 + 8'd11;
      cct2 <= p2a;
    end
  end

  function automatic logic [7:0] resp(input int sel, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (sel)
      1:       resp = (kb ^ 8'hA5) + 8'd17;
      2:       resp = kb * 8'd37 + 8'd11;
      default: resp = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] model_sig(input logic [7:0] s, input int n, input int sel);
    logic [15:0] sg;
    logic [7:0]  a;
    sg = 16'h0000;
    for (int k = 0; k < n; k++) begin
      a  = sg[7:0] + (s ^ resp(sel, k));
      sg = {sg[14:8], a, sg[15]};
    end
    model_sig = sg;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic flagError(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", name);
  endtask

  // lat < 0 means the run will be aborted, so nothing is queued.
  task automatic applyStimulus(input int which, input logic [7:0] s, input logic [15:0] g,
                               input logic [15:0] esig, input logic epass, input int lat);
    exp_t e;
    e.sig  = esig;
    e.pass = epass;
    e.cyc  = cyc + lat;
    case (which)
      0: begin seed0 = s; golden0 = g; start0 = 1'b1; if (lat >= 0) q0.push_back(e); end
      1: begin seed1 = s; golden1 = g; start1 = 1'b1; if (lat >= 0) q1.push_back(e); end
      default: begin seed2 = s; golden2 = g; start2 = 1'b1; if (lat >= 0) q2.push_back(e); end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitDone(input int which, input int budget);
    int n;
    int sz;
    n  = 0;
    sz = 1;
    while (sz != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      sz = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
    end
    if (sz != 0) begin
      flagError($sformatf("done_timeout_dut%0d", which));
      if (which == 0) q0.delete();
      else if (which == 1) q1.delete();
      else q2.delete();
    end
  endtask

  task automatic waitStim0(input logic [7:0] v, input int budget);
    int n;
    n = 0;
    while (stim0 !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (stim0 !== v) flagError($sformatf("stimulus_never_reached_%0h", v));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) flagError("d0_unexpected_done");
      else begin
        e = q0.pop_front();
        checkOutput("d0_signature", 32'(sig0), 32'(e.sig));
        checkOutput("d0_pass", 32'(pass0), 32'(e.pass));
        checkOutput("d0_done_cycle", cyc, e.cyc);
        checkOutput("d0_busy_at_done", 32'(busy0), 32'd0);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) flagError("d1_unexpected_done");
      else begin
        e = q1.pop_front();
        checkOutput("d1_signature", 32'(sig1), 32'(e.sig));
        checkOutput("d1_pass", 32'(pass1), 32'(e.pass));
        checkOutput("d1_done_cycle", cyc, e.cyc);
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) flagError("d2_unexpected_done");
      else begin
        e = q2.pop_front();
        checkOutput("d2_signature", 32'(sig2), 32'(e.sig));
        checkOutput("d2_pass", 32'(pass2), 32'(e.pass));
        checkOutput("d2_done_cycle", cyc, e.cyc);
        checkOutput("d2_stimulus_saturated", 32'(stim2), 32'd7);
      end
    end
  end

  initial begin
    logic [15:0] m;
    clear0 = 1'b1; clear1 = 1'b1; clear2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    seed0 = 8'h00; seed1 = 8'h00; seed2 = 8'h00;
    golden0 = 16'h0000; golden1 = 16'h0000; golden2 = 16'h0000;
    cct1 = 8'h00; cut_mode0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stimulus", 32'(stim0), 32'd0);
    checkOutput("reset_signature", 32'(sig0), 32'd0);
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_done", 32'(done0), 32'd0);
    checkOutput("reset_pass", 32'(pass0), 32'd0);
    checkOutput("reset_cut_clear", 32'(cut_clear0), 32'd1);
    checkOutput("reset_cut_clear_d1", 32'(cut_clear1), 32'd1);
    clear0 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
    @(negedge clk);

    // All-zero response with zero seed keeps the signature at zero.
    applyStimulus(0, 8'h00, 16'h0000, 16'h0000, 1'b1, 261);
    waitDone(0, 400);

    // Two-sample sweep: 0002 then 0006; the second start lands in the done cycle.
    applyStimulus(1, 8'h01, 16'h0006, 16'h0006, 1'b1, 5);
    waitDone(1, 20);
    checkOutput("d1_done_visible_at_restart", 32'(done1), 32'd1);
    applyStimulus(1, 8'h01, 16'h0007, 16'h0006, 1'b0, 5);
    waitDone(1, 20);

    // Abort mid-sweep with clear.
    cut_mode0 = 1'b1;
    applyStimulus(0, 8'h3C, 16'h0000, 16'h0000, 1'b0, -1);
    waitStim0(8'h40, 300);
    clear0 = 1'b1;
    @(posedge clk);
    #1;
    clear0 = 1'b0;
    checkOutput("abort_stimulus", 32'(stim0), 32'd0);
    checkOutput("abort_signature", 32'(sig0), 32'd0);
    checkOutput("abort_busy", 32'(busy0), 32'd0);
    checkOutput("abort_cut_clear", 32'(cut_clear0), 32'd1);
    repeat (270) @(negedge clk);

    // Re-pulsed start with new seed/golden during RUN is ignored.
    m = model_sig(8'h3C, 256, 1);
    applyStimulus(0, 8'h3C, m, m, 1'b1, 261);
    waitStim0(8'h10, 300);
    checkOutput("busy_during_run", 32'(busy0), 32'd1);
    seed0 = 8'hFF; golden0 = 16'hDEAD; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(0, 400);

    // Clear pulse that misses every rising edge has no effect.
    m = model_sig(8'h5A, 256, 1);
    applyStimulus(0, 8'h5A, m, m, 1'b1, 261);
    waitStim0(8'h80, 300);
    #1 clear0 = 1'b1;
    #3 clear0 = 1'b0;
    waitDone(0, 400);

    // Deeper CUT pipeline, matching and non-matching golden values.
    m = model_sig(8'hC3, 8, 2);
    applyStimulus(2, 8'hC3, m, m, 1'b1, 15);
    waitDone(2, 40);
    m = model_sig(8'h00, 8, 2);
    applyStimulus(2, 8'h00, 16'h1234, m, (m == 16'h1234), 15);
    waitDone(2, 40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
